// File: rtl/tn_accum_sequencer_pkg.sv
// rtl/tn_accum_sequencer_pkg.sv - shared constants and state type for the Tn-lane accumulation sequencer
package tn_accum_sequencer_pkg;

    localparam int TN_DEFAULT            = 4;
    localparam int FEATURE_WIDTH_DEFAULT = 16;
    localparam int KERNEL_SIZE           = 3;
    localparam int ACC_WIDTH_DEFAULT     = 32;
    localparam int GROUP_W_DEFAULT       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/tn_lane_acc.sv
// rtl/tn_lane_acc.sv - one lane's sign-extending, wrapping accumulator
module tn_lane_acc #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_add_en,
    input  logic [IN_W-1:0]  i_din,
    output logic [ACC_W-1:0] o_acc
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_ext;

    assign w_ext = ACC_W'($signed(i_din));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_acc <= '0;
        end else if (i_add_en) begin
            r_acc <= r_acc + w_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/tn_accum_sequencer.sv
// rtl/tn_accum_sequencer.sv - issues tiles to the Tn-lane adder tree and accumulates its results per lane
module tn_accum_sequencer
    import tn_accum_sequencer_pkg::*;
#(
    parameter int Tn            = TN_DEFAULT,
    parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEFAULT,
    parameter int ACC_WIDTH     = ACC_WIDTH_DEFAULT,
    parameter int GROUP_W       = GROUP_W_DEFAULT
) (
    input  logic                        fast_clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [GROUP_W-1:0]          cfg_groups,
    output logic                        busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        tree_enable,
    input  logic                        tree_done,
    input  logic [Tn*FEATURE_WIDTH-1:0] kernel_sum_tn,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [Tn*ACC_WIDTH-1:0]     out_data,
    output logic                        done
);

    state_e             r_state;
    state_e             w_next;
    logic [GROUP_W-1:0] r_groups;
    logic [GROUP_W-1:0] r_issued;
    logic [GROUP_W-1:0] r_retired;
    logic               r_done;

    logic w_start_acc;
    logic w_accept;
    logic w_retire;
    logic w_last_accept;
    logic w_last_retire;

    assign w_start_acc   = (r_state == IDLE) && start;
    assign w_accept      = in_valid && in_ready;
    assign w_retire      = tree_done && ((r_state == RUN) || (r_state == DRAIN));
    assign w_last_accept = w_accept && ((r_issued + GROUP_W'(1)) == r_groups);
    assign w_last_retire = w_retire && ((r_retired + GROUP_W'(1)) == r_groups);

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (cfg_groups == '0) ? OUT : RUN;
                end
            end
            RUN: begin
                // A final retire wins over the final accept so a zero-latency tree cannot strand the job in DRAIN.
                if (w_last_retire) begin
                    w_next = OUT;
                end else if (w_last_accept) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_retire) begin
                    w_next = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != IDLE);
        in_ready    = (r_state == RUN) && (r_issued != r_groups);
        tree_enable = in_valid && in_ready;
        out_valid   = (r_state == OUT);
        done        = r_done;
    end

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            r_groups  <= '0;
            r_issued  <= '0;
            r_retired <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == OUT) && out_ready;
            if (w_start_acc) begin
                r_groups  <= cfg_groups;
                r_issued  <= '0;
                r_retired <= '0;
            end else begin
                if (w_accept) begin
                    r_issued <= r_issued + GROUP_W'(1);
                end
                if (w_retire) begin
                    r_retired <= r_retired + GROUP_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < Tn; g++) begin : g_lane
        tn_lane_acc #(
            .IN_W  (FEATURE_WIDTH),
            .ACC_W (ACC_WIDTH)
        ) u_lane (
            .i_clk    (fast_clk),
            .i_rst    (rst),
            .i_clear  (w_start_acc),
            .i_add_en (w_retire),
            .i_din    (kernel_sum_tn[g*FEATURE_WIDTH +: FEATURE_WIDTH]),
            .o_acc    (out_data[g*ACC_WIDTH +: ACC_WIDTH])
        );
    end

endmodule

// File: tb/tb_tn_accum_sequencer.sv
// tb/tb_tn_accum_sequencer.sv - directed bench with a job-level reference model and a 4-cycle tree emulator
module tb_tn_accum_sequencer;

    localparam int TN = 4;
    localparam int FW = 16;
    localparam int AW = 32;
    localparam int GW = 8;

    logic              fast_clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [GW-1:0]     cfg_groups = '0;
    logic              in_valid = 1'b0;
    logic              tree_done = 1'b0;
    logic [TN*FW-1:0]  kernel_sum_tn = '0;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              in_ready;
    logic              tree_enable;
    logic              out_valid;
    logic [TN*AW-1:0]  out_data;
    logic              done;

    tn_accum_sequencer #(
        .Tn            (TN),
        .FEATURE_WIDTH (FW),
        .ACC_WIDTH     (AW),
        .GROUP_W       (GW)
    ) dut (
        .fast_clk      (fast_clk),
        .rst           (rst),
        .start         (start),
        .cfg_groups    (cfg_groups),
        .busy          (busy),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .tree_enable   (tree_enable),
        .tree_done     (tree_done),
        .kernel_sum_tn (kernel_sum_tn),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .done          (done)
    );

    always #5 fast_clk = ~fast_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge fast_clk) cyc <= cyc + 1;

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0b required=%0b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] lanes(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Tree emulator: every enable returns the next queued tile 4 cycles later.
    logic [63:0] tile_q[$];
    logic [63:0] val_q[$];
    int          due_q[$];
    int          n_enable = 0;

    always @(negedge fast_clk) begin
        if (tree_enable) begin
            n_enable++;
            due_q.push_back(cyc + 4);
            if (tile_q.size() > 0) val_q.push_back(tile_q.pop_front());
            else val_q.push_back(64'h0);
        end
    end

    always @(posedge fast_clk) begin
        #1;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            tree_done     = 1'b1;
            kernel_sum_tn = val_q.pop_front();
            void'(due_q.pop_front());
        end else begin
            tree_done     = 1'b0;
            kernel_sum_tn = {$urandom, $urandom};
        end
    end

    // Job-level model: phase 0 idle, 1 collecting tiles, 2 presenting the result.
    logic         mon_on = 1'b0;
    int           m_phase = 0;
    int           m_groups = 0;
    int           m_iss = 0;
    int           m_ret = 0;
    logic [31:0]  m_acc[TN];
    logic         m_done_pend = 1'b0;
    int           done_cnt = 0;
    int           last_done_cyc = 0;
    int           hs_cyc = 0;
    logic [127:0] hs_data = '0;

    initial for (int i = 0; i < TN; i++) m_acc[i] = '0;

    always @(negedge fast_clk) begin : mon
        logic [127:0] exp_data;
        logic         exp_ready;
        if (mon_on) begin
            for (int i = 0; i < TN; i++) exp_data[i*32 +: 32] = m_acc[i];
            exp_ready = (m_phase == 1) && (m_iss != m_groups);
            chk1("busy", busy, m_phase != 0);
            chk1("in_ready", in_ready, exp_ready);
            chk1("tree_enable", tree_enable, in_valid && exp_ready);
            chk1("out_valid", out_valid, m_phase == 2);
            chk1("done", done, m_done_pend);
            chkw("out_data", out_data, exp_data);
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                hs_data = out_data;
                hs_cyc  = cyc;
            end
            if (rst) begin
                m_phase = 0; m_groups = 0; m_iss = 0; m_ret = 0; m_done_pend = 1'b0;
                for (int i = 0; i < TN; i++) m_acc[i] = '0;
            end else begin
                m_done_pend = (m_phase == 2) && out_ready;
                case (m_phase)
                    0: if (start) begin
                        m_groups = int'(cfg_groups);
                        m_iss = 0;
                        m_ret = 0;
                        for (int i = 0; i < TN; i++) m_acc[i] = '0;
                        m_phase = (cfg_groups == 0) ? 2 : 1;
                    end
                    1: begin
                        if (in_valid && m_iss != m_groups) m_iss++;
                        if (tree_done) begin
                            for (int i = 0; i < TN; i++)
                                m_acc[i] = m_acc[i] + {{16{kernel_sum_tn[i*16+15]}}, kernel_sum_tn[i*16 +: 16]};
                            m_ret++;
                            if (m_ret == m_groups) m_phase = 2;
                        end
                    end
                    default: if (out_ready) m_phase = 0;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int c0;
        int k;
        c0 = done_cnt;
        k = 0;
        while (done_cnt == c0 && k < budget) begin
            tick();
            k++;
        end
        chk1({nm, "_done_seen"}, done_cnt != c0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int k;
        tick();
        mon_on = 1'b1;
        tick();
        @(negedge fast_clk);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_out_valid", out_valid, 1'b0);
        chkw("reset_out_data", out_data, 128'h0);
        tick();
        rst = 1'b0;
        tick();

        // Back-to-back tiles of 1, 2, 3 on every lane
        tile_q.push_back(lanes(1, 1, 1, 1));
        tile_q.push_back(lanes(2, 2, 2, 2));
        tile_q.push_back(lanes(3, 3, 3, 3));
        n_enable = 0;
        start = 1'b1; cfg_groups = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
        s0 = cyc;
        tick();
        start = 1'b0;
        wait_done("t1", 40);
        in_valid = 1'b0;
        chkw("t1_sum", hs_data, {4{32'd6}});
        chki("t1_enables", n_enable, 3);
        chki("t1_latency", last_done_cyc - s0, 9);
        chki("t1_done_gap", last_done_cyc - hs_cyc, 1);
        tick();

        // Sign extension and wrap
        tile_q.push_back(lanes(16'hFFFF, 16'h7FFF, 16'h0001, 16'h8000));
        tile_q.push_back(lanes(16'hFFFF, 16'h7FFF, 16'h0001, 16'h8000));
        start = 1'b1; cfg_groups = 8'd2; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t2", 40);
        in_valid = 1'b0;
        chkw("t2_sum", hs_data, {32'hFFFF0000, 32'h00000002, 32'h0000FFFE, 32'hFFFFFFFE});
        tick();

        // Gapped input, output back-pressure
        tile_q.push_back(lanes(16'd10, 16'd20, 16'd30, 16'd40));
        tile_q.push_back(lanes(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC));
        start = 1'b1; cfg_groups = 8'd2; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        start = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (k < 40) begin
            @(negedge fast_clk);
            if (out_valid) break;
            k++;
        end
        chk1("t3_out_valid_seen", out_valid, 1'b1);
        repeat (5) begin
            tick();
            @(negedge fast_clk);
            chk1("t3_hold_valid", out_valid, 1'b1);
            chkw("t3_hold_data", out_data, {32'd36, 32'd27, 32'd18, 32'd9});
            chk1("t3_no_done", done, 1'b0);
        end
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_done("t3", 10);
        chkw("t3_sum", hs_data, {32'd36, 32'd27, 32'd18, 32'd9});
        tick();

        // Zero-tile job
        n_enable = 0;
        start = 1'b1; cfg_groups = 8'd0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        @(negedge fast_clk);
        chk1("t4_out_valid_c1", out_valid, 1'b1);
        chkw("t4_out_data_c1", out_data, 128'h0);
        tick();
        out_ready = 1'b1;
        wait_done("t4", 10);
        out_ready = 1'b0; in_valid = 1'b0;
        chki("t4_enables", n_enable, 0);
        tick();

        // start while busy is ignored
        tile_q.push_back(lanes(7, 7, 7, 7));
        tile_q.push_back(lanes(8, 8, 8, 8));
        n_enable = 0;
        start = 1'b1; cfg_groups = 8'd2; in_valid = 1'b1; out_ready = 1'b1;
        s0 = cyc;
        tick();
        start = 1'b1; cfg_groups = 8'd9;
        tick();
        start = 1'b0;
        wait_done("t5", 40);
        in_valid = 1'b0;
        chki("t5_enables", n_enable, 2);
        chki("t5_latency", last_done_cyc - s0, 8);
        chkw("t5_sum", hs_data, {4{32'd15}});
        tick();

        // Reset in DRAIN with one result in flight, then a fresh one-tile job
        tile_q.push_back(lanes(3, 3, 3, 3));
        tile_q.push_back(lanes(100, 100, 100, 100));
        tile_q.push_back(lanes(5, 5, 5, 5));
        start = 1'b1; cfg_groups = 8'd2; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge fast_clk);
        chk1("t6_rst_busy", busy, 1'b0);
        chk1("t6_rst_out_valid", out_valid, 1'b0);
        chkw("t6_rst_out_data", out_data, 128'h0);
        tick();
        tick();
        tick();
        @(negedge fast_clk);
        chkw("t6_late_ignored", out_data, 128'h0);
        chk1("t6_late_idle", busy, 1'b0);
        tick();
        n_enable = 0;
        start = 1'b1; cfg_groups = 8'd1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6", 40);
        in_valid = 1'b0; out_ready = 1'b0;
        chkw("t6_sum", hs_data, {4{32'd5}});
        chki("t6_enables", n_enable, 1);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tn_accum_sequencer.md
# tn_accum_sequencer

Sequences the Tn-lane kernel adder tree across multiple input-channel tiles and accumulates its per-lane partial sums. For each of `cfg_groups` tiles it accepts a tile from the upstream ternary-product stage and pulses the tree enable. It adds each returned `kernel_sum_tn` into a per-lane accumulator. When all tiles have retired, it presents the Tn accumulated sums on a valid/ready output toward the scaler-multiply stage.

## Interface
Parameters:
- `Tn`, 4: number of lanes (kernels) in the tree.
- `FEATURE_WIDTH`, 16: width of each lane in `kernel_sum_tn`.
- `ACC_WIDTH`, 32: per-lane accumulator width; must be ≥ FEATURE_WIDTH.
- `GROUP_W`, 8: width of the tile count.

Ports:
- `fast_clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle request to begin a job; honoured only in IDLE.
- `cfg_groups` in GROUP_W: number of tiles to accumulate; latched when `start` is accepted.
- `busy` out 1: high in every state except IDLE.
- `in_valid` in 1: upstream has a tile ready on the tree inputs.
- `in_ready` out 1: sequencer will accept a tile this cycle.
- `tree_enable` out 1: equals `in_valid & in_ready`; combinational. Drives the tree's `enable`.
- `tree_done` in 1: adder-tree result valid this cycle.
- `kernel_sum_tn` in Tn*FEATURE_WIDTH: tree results; lane i occupies bits [(i+1)*FEATURE_WIDTH-1 : i*FEATURE_WIDTH].
- `out_valid` out 1: accumulated result available.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out Tn*ACC_WIDTH: per-lane accumulators, packed the same way as `kernel_sum_tn`.
- `done` out 1: one-cycle pulse in the cycle after the output handshake.

## Operation
States:
- **IDLE**
  - On `start`: latch `cfg_groups`, clear all accumulators, clear `issued` and `retired`.
  - If `cfg_groups == 0`, go to OUT; otherwise go to RUN.
- **RUN**
  - `in_ready = (issued != groups)`.
  - Each accept increments `issued`.
  - Go to DRAIN when `issued` reaches `groups`, i.e. in the cycle after the last accept.
- **DRAIN**
  - `in_ready = 0`; waits for the outstanding retires.
- **OUT**
  - `out_valid = 1`; `out_data` is held stable.
  - On `out_valid & out_ready`: go to IDLE and pulse `done` in the next cycle.

Retirement:
- `tree_done` is honoured in RUN and DRAIN.
- On each honoured `tree_done`, every lane accumulator adds its lane of `kernel_sum_tn`, and `retired` increments.
- When `retired + 1 == groups` on a `tree_done`, the next state is OUT. This applies from DRAIN, or directly from RUN if the last accept has already occurred.

Arithmetic:
- Each lane of `kernel_sum_tn` is two's-complement; it is sign-extended to ACC_WIDTH before adding.
- Overflow wraps modulo 2^ACC_WIDTH; no saturation.

Boundary conditions:
- Accept and retire in the same cycle: both counters update.
- `tree_done` in IDLE or OUT: ignored; accumulators are unchanged.
- `start` while `busy`: ignored; the latched `groups` is unchanged.
- `in_valid` outside RUN, or in RUN with `issued == groups`: no accept, no `tree_enable`.
- `rst` at any time, including mid-job, forces:
  - state IDLE;
  - all accumulators 0, `issued = 0`, `retired = 0`;
  - `busy = 0`, `in_ready = 0`, `out_valid = 0`, `done = 0`, `out_data = 0`.
  - Tree results still in flight after a reset are ignored because the state is IDLE.

## Timing
- `start` sampled at edge 0 → `busy` and `in_ready` high in cycle 1.
- Accept in cycle t → `tree_enable` high in cycle t; the tree returns `tree_done` 4 cycles later. The sequencer does not count latency; it trusts `tree_done`.
- The sequencer imposes no back-to-back limit: a new tile can be accepted every cycle.
- Last `tree_done` in cycle d → accumulators updated at edge d+1 → `out_valid` high in cycle d+1.
- Output handshake in cycle h → `done` high and `busy` low in cycle h+1. A new `start` is accepted in cycle h+1.
- `cfg_groups = 0`: `start` at edge 0 → `out_valid` high with `out_data = 0` in cycle 1.
- Minimum job of G tiles with `out_ready` held high: `start` to `done` = G + 6 cycles.

## Structure
- Shared package:
  - state enum {IDLE, RUN, DRAIN, OUT};
  - default ACC_WIDTH and GROUP_W constants next to the existing FEATURE_WIDTH, Tn and KERNEL_SIZE defines.
- Sub-module `tn_lane_acc`, instantiated Tn times via generate. It holds one lane's sign-extended accumulator with `clear` and `add_en` controls.
- Control FSM and counters live in the top module.

## Test plan
- Tn=4, `cfg_groups=3`, tiles back-to-back, each lane returning 1, 2, 3 → `out_data` lanes all 6; `done` 1 cycle after the handshake; exactly 3 `tree_enable` pulses.
- Lane 0 returns 16'hFFFF twice with ACC_WIDTH=32 → lane 0 = 32'hFFFFFFFE (−2).
- `cfg_groups=2`, `in_valid` gapped, `out_ready` held low 5 cycles → `out_valid` and `out_data` stable for 5 cycles; no `done` until the handshake.
- `cfg_groups=0` → `out_valid` in cycle 1, `out_data=0`, no `tree_enable` pulses.
- `start` pulsed during RUN with `cfg_groups=9`, original `cfg_groups=2` → the job completes after 2 retires.
- `rst` asserted in DRAIN with 1 result outstanding, then a late `tree_done` → all outputs 0 and state IDLE. A new job with `cfg_groups=1`, lane value 5, yields exactly 5.
